pac_status_monitor: RTL and testbench
=====================================

Name: pac_status_monitor

Overview:
- Game-state responder on the far side of the pac_control interface: generates PAC_status and dots_status from gameplay events, and consumes the level, Starting_screen and ResetAll outputs of pac_control.
- Tracks dots remaining, lives, score, the frightened (power-pellet) window and the death sequence.
- Sits between the sprite/collision/dot-RAM logic and pac_control.

Parameters:
- DOTS_L1, 240, dot total loaded for level 1 (power pellets included).
- DOTS_L2, 244, dot total loaded for level 2.
- LIVES, 3, lives at new game (1..3).
- DEATH_FRAMES, 60, frame_ticks spent in DYING.
- FRIGHT_FRAMES, 120, frame_ticks of frightened mode per power pellet.

Ports:
- Clk in 1: system clock.
- Reset in 1: synchronous, active-high.
- frame_tick in 1: one-Clk pulse per video frame.
- ResetAll in 1: from pac_control; requests level/game reload.
- level in 2: from pac_control; 1 or 2.
- Starting_screen in 1: from pac_control; all events are ignored while high.
- dot_eaten in 1: one-Clk pulse; Pac consumed a normal dot.
- power_eaten in 1: one-Clk pulse; Pac consumed a power pellet.
- ghost_hit in 1: one-Clk pulse; Pac overlaps a ghost.
- PAC_status out 1: high = Pac dead (game over).
- dots_status out 1: high = dots remain.
- dots_left out 8: remaining dot count.
- lives out 2: lives remaining.
- score out 16: current score.
- frightened out 1: ghosts vulnerable.
- dying out 1: death animation active.
- respawn out 1: one-Clk pulse telling sprite logic to reposition after a non-final death.

Behaviour:
- FSM states: LOAD, PLAY, DYING, DEAD. All outputs are registered.
- Reset: state LOAD, dots_left=DOTS_L1, lives=LIVES, score=0, PAC_status=0, frightened=0, dying=0, respawn=0, fright and death counters 0. dots_status=1.
- dots_status is (dots_left != 0), registered with dots_left.
- ResetAll high (any state, priority over all events): next cycle dots_left = DOTS_L2 if level==2, else DOTS_L1.
  - Also clears frightened, dying and both counters; PAC_status goes 0; state goes LOAD.
  - If state was DEAD when ResetAll was sampled, lives reloads to LIVES and score clears to 0. Otherwise lives and score are held.
- LOAD -> PLAY on the first cycle with ResetAll low.
- PLAY: events count only when Starting_screen=0.
  - dot_eaten: dots_left-1, score+10.
  - power_eaten: dots_left-1, score+50; frightened=1 and the fright counter loads FRIGHT_FRAMES (a re-trigger restarts it).
  - dot_eaten and power_eaten in the same cycle: treated as power_eaten only; single decrement.
  - dots_left floors at 0; further dot events are ignored.
  - ghost_hit with frightened=1: score+200, no state change.
  - ghost_hit with frightened=0: enter DYING; any dot/power event in the same cycle is discarded, so dots_left is unchanged.
- Score saturates at 65535; additions in the same cycle sum before saturating.
- Fright counter decrements on frame_tick in PLAY. frightened drops the cycle after the counter reaches 0.
- DYING: dying=1 and frightened=0; the death counter loads DEATH_FRAMES on entry and decrements on frame_tick.
  - On the tick where the counter hits 0 with lives>1: lives-1, respawn pulses for 1 cycle, back to PLAY.
  - With lives==1: lives=0, go to DEAD.
  - Events are ignored in DYING.
- DEAD: PAC_status=1, held until ResetAll is sampled high; it drops the cycle after.
  - pac_control answers PAC_status with ResetAll the next cycle, so PAC_status lasts exactly 2 cycles in normal operation.
- frame_tick arriving in the same cycle as state entry does not decrement the freshly loaded counter.

Test Plan:
- Reset, then 240 dot_eaten pulses in PLAY with ResetAll=0 and Starting_screen=0 -> dots_left 240->0; dots_status falls after the 240th pulse; score=2400; a 241st pulse leaves dots_left=0 and score=2400.
- After level 1 is cleared, ResetAll=1 for 1 cycle with level=2 -> dots_left=244, dots_status=1, score and lives unchanged, state LOAD then PLAY.
- power_eaten then 119 frame_ticks -> frightened=1; ghost_hit adds 200 with no DYING. The 120th tick drops frightened; a subsequent ghost_hit enters DYING.
- ghost_hit with lives=3 -> dying=1 for 60 ticks, then lives=2, one-cycle respawn pulse, state PLAY, dots_left unchanged.
- Third death -> after 60 ticks PAC_status=1. Assert ResetAll one cycle later with level=1 -> PAC_status=0, lives=3, score=0, dots_left=240.
- Last dot_eaten coincident with a non-frightened ghost_hit -> dots_left stays 1, dots_status stays 1, DYING entered. Separately, dot_eaten while Starting_screen=1 leaves dots_left unchanged.

Source files
------------

// File: rtl/pac_status_monitor_if.sv
// Event and status bundle between the gameplay logic / pac_control and the status monitor.
// Events are single-Clk pulses; status outputs are registered and hold until changed.
interface pac_status_monitor_if;
    logic       frame_tick;
    logic       ResetAll;
    logic [1:0] level;
    logic       Starting_screen;
    logic       dot_eaten;
    logic       power_eaten;
    logic       ghost_hit;
    logic       PAC_status;
    logic       dots_status;
    logic [7:0] dots_left;
    logic [1:0] lives;
    logic [15:0] score;
    logic       frightened;
    logic       dying;
    logic       respawn;
    logic [1:0] dbg_state;

    modport slave (
        input  frame_tick, ResetAll, level, Starting_screen, dot_eaten, power_eaten, ghost_hit,
        output PAC_status, dots_status, dots_left, lives, score, frightened, dying, respawn, dbg_state
    );

    modport master (
        output frame_tick, ResetAll, level, Starting_screen, dot_eaten, power_eaten, ghost_hit,
        input  PAC_status, dots_status, dots_left, lives, score, frightened, dying, respawn, dbg_state
    );
endinterface

// File: rtl/pac_status_monitor.sv
// Game-state responder for pac_control: dots, lives, score, frightened window and death sequence.
// dbg_state exposes the FSM encoding: 0=LOAD 1=PLAY 2=DYING 3=DEAD.
module pac_status_monitor #(
    parameter int unsigned DOTS_L1       = 240,
    parameter int unsigned DOTS_L2       = 244,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned DEATH_FRAMES  = 60,
    parameter int unsigned FRIGHT_FRAMES = 120
) (
    input logic                 Clk,
    input logic                 Reset,
    pac_status_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } state_e;

    localparam logic [7:0]  DOTS_L1_C = 8'(DOTS_L1);
    localparam logic [7:0]  DOTS_L2_C = 8'(DOTS_L2);
    localparam logic [1:0]  LIVES_C   = 2'(LIVES);
    localparam logic [15:0] DEATH_C   = 16'(DEATH_FRAMES);
    localparam logic [15:0] FRIGHT_C  = 16'(FRIGHT_FRAMES);

    state_e      state_q, state_d;
    logic [7:0]  dots_left_q, dots_left_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic [15:0] fright_cnt_q, fright_cnt_d;
    logic [15:0] death_cnt_q, death_cnt_d;
    logic        frightened_q, frightened_d;
    logic        dying_q, dying_d;
    logic        respawn_q, respawn_d;
    logic        pac_q, pac_d;
    logic        dots_status_q;

    logic        ev_ok, fatal_hit, dot_ev, pwr_ev, bonus_ev;
    logic [8:0]  score_add;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    // A non-frightened ghost hit swallows any dot/power event in the same cycle.
    always_comb begin
        ev_ok     = (state_q == PLAY) && !bus.Starting_screen;
        fatal_hit = ev_ok && bus.ghost_hit && !frightened_q;
        dot_ev    = ev_ok && !fatal_hit && (bus.dot_eaten || bus.power_eaten) && (dots_left_q != 8'd0);
        pwr_ev    = dot_ev && bus.power_eaten;
        bonus_ev  = ev_ok && bus.ghost_hit && frightened_q;
        score_add = 9'd0;
        if (dot_ev) begin
            score_add = pwr_ev ? 9'd50 : 9'd10;
        end
        if (bonus_ev) begin
            score_add = score_add + 9'd200;
        end
        score_sum = {1'b0, score_q} + 17'(score_add);
        score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_comb begin
        state_d      = state_q;
        dots_left_d  = dots_left_q;
        lives_d      = lives_q;
        score_d      = score_q;
        fright_cnt_d = fright_cnt_q;
        death_cnt_d  = death_cnt_q;
        frightened_d = frightened_q;
        dying_d      = dying_q;
        respawn_d    = 1'b0;
        pac_d        = pac_q;

        if (bus.ResetAll) begin
            dots_left_d  = (bus.level == 2'd2) ? DOTS_L2_C : DOTS_L1_C;
            frightened_d = 1'b0;
            dying_d      = 1'b0;
            fright_cnt_d = 16'd0;
            death_cnt_d  = 16'd0;
            pac_d        = 1'b0;
            state_d      = LOAD;
            if (state_q == DEAD) begin
                lives_d = LIVES_C;
                score_d = 16'd0;
            end
        end else begin
            case (state_q)
                LOAD: state_d = PLAY;
                PLAY: begin
                    if (bus.frame_tick && fright_cnt_q != 16'd0) begin
                        fright_cnt_d = fright_cnt_q - 16'd1;
                    end
                    if (frightened_q && fright_cnt_q == 16'd0) begin
                        frightened_d = 1'b0;
                    end
                    if (fatal_hit) begin
                        state_d      = DYING;
                        dying_d      = 1'b1;
                        frightened_d = 1'b0;
                        fright_cnt_d = 16'd0;
                        death_cnt_d  = DEATH_C;
                    end else begin
                        score_d = score_sat;
                        if (dot_ev) begin
                            dots_left_d = dots_left_q - 8'd1;
                        end
                        if (pwr_ev) begin
                            frightened_d = 1'b1;
                            fright_cnt_d = FRIGHT_C;
                        end
                    end
                end
                DYING: begin
                    if (bus.frame_tick) begin
                        if (death_cnt_q <= 16'd1) begin
                            death_cnt_d = 16'd0;
                            dying_d     = 1'b0;
                            if (lives_q > 2'd1) begin
                                lives_d   = lives_q - 2'd1;
                                respawn_d = 1'b1;
                                state_d   = PLAY;
                            end else begin
                                lives_d = 2'd0;
                                pac_d   = 1'b1;
                                state_d = DEAD;
                            end
                        end else begin
                            death_cnt_d = death_cnt_q - 16'd1;
                        end
                    end
                end
                DEAD: state_d = DEAD;
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= LOAD;
            dots_left_q   <= DOTS_L1_C;
            lives_q       <= LIVES_C;
            score_q       <= 16'd0;
            fright_cnt_q  <= 16'd0;
            death_cnt_q   <= 16'd0;
            frightened_q  <= 1'b0;
            dying_q       <= 1'b0;
            respawn_q     <= 1'b0;
            pac_q         <= 1'b0;
            dots_status_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            dots_left_q   <= dots_left_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            fright_cnt_q  <= fright_cnt_d;
            death_cnt_q   <= death_cnt_d;
            frightened_q  <= frightened_d;
            dying_q       <= dying_d;
            respawn_q     <= respawn_d;
            pac_q         <= pac_d;
            dots_status_q <= (dots_left_d != 8'd0);
        end
    end

    assign bus.PAC_status  = pac_q;
    assign bus.dots_status = dots_status_q;
    assign bus.dots_left   = dots_left_q;
    assign bus.lives       = lives_q;
    assign bus.score       = score_q;
    assign bus.frightened  = frightened_q;
    assign bus.dying       = dying_q;
    assign bus.respawn     = respawn_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_pac_status_monitor.sv
// Bench for pac_status_monitor: constant vector table, scripted game sequences, and a
// randomized run checked every cycle against a game-rule reference model.
module tb_pac_status_monitor;

    logic Clk = 1'b0;
    logic Reset;
    pac_status_monitor_if bus();

    pac_status_monitor dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    localparam int M_LOAD  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DYING = 2;
    localparam int M_DEAD  = 3;

    // Reference game model: plain integers updated from the game rules once per cycle.
    int m_mode, m_dots, m_lives, m_score, m_ftimer, m_dtimer;
    int m_fright, m_dying, m_respawn, m_pac;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_mode = M_LOAD; m_dots = 240; m_lives = 3; m_score = 0;
        m_ftimer = 0; m_dtimer = 0; m_fright = 0; m_dying = 0; m_respawn = 0; m_pac = 0;
    endtask

    task automatic model_step(input bit ra, input bit [1:0] lvl, input bit ss, input bit dot,
                              input bit pwr, input bit gh, input bit tick);
        int fr_before;
        int gain;
        fr_before = m_fright;
        gain = 0;
        m_respawn = 0;
        if (ra) begin
            if (m_mode == M_DEAD) begin
                m_lives = 3;
                m_score = 0;
            end
            m_dots = (lvl == 2'd2) ? 244 : 240;
            m_fright = 0; m_ftimer = 0; m_dtimer = 0; m_dying = 0; m_pac = 0;
            m_mode = M_LOAD;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            if (fr_before == 1 && m_ftimer == 0) m_fright = 0;
            if (tick && m_ftimer > 0) m_ftimer--;
            if (!ss && gh && fr_before == 0) begin
                m_mode = M_DYING; m_dying = 1; m_fright = 0; m_ftimer = 0; m_dtimer = 60;
            end else if (!ss) begin
                if ((dot || pwr) && m_dots > 0) begin
                    m_dots--;
                    if (pwr) begin
                        gain += 50;
                        m_fright = 1;
                        m_ftimer = 120;
                    end else begin
                        gain += 10;
                    end
                end
                if (gh) gain += 200;
                m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
            end
        end else if (m_mode == M_DYING && tick) begin
            m_dtimer--;
            if (m_dtimer == 0) begin
                m_dying = 0;
                if (m_lives > 1) begin
                    m_lives--; m_respawn = 1; m_mode = M_PLAY;
                end else begin
                    m_lives = 0; m_pac = 1; m_mode = M_DEAD;
                end
            end
        end
    endtask

    task automatic compare_model();
        check("model_state",      32'(bus.dbg_state),   m_mode);
        check("model_dots_left",  32'(bus.dots_left),   m_dots);
        check("model_dots_status",32'(bus.dots_status), (m_dots != 0) ? 1 : 0);
        check("model_lives",      32'(bus.lives),       m_lives);
        check("model_score",      32'(bus.score),       m_score);
        check("model_frightened", 32'(bus.frightened),  m_fright);
        check("model_dying",      32'(bus.dying),       m_dying);
        check("model_respawn",    32'(bus.respawn),     m_respawn);
        check("model_PAC_status", 32'(bus.PAC_status),  m_pac);
    endtask

    task automatic step(input bit ra, input bit [1:0] lvl, input bit ss, input bit dot,
                        input bit pwr, input bit gh, input bit tick);
        bus.ResetAll = ra; bus.level = lvl; bus.Starting_screen = ss;
        bus.dot_eaten = dot; bus.power_eaten = pwr; bus.ghost_hit = gh; bus.frame_tick = tick;
        model_step(ra, lvl, ss, dot, pwr, gh, tick);
        @(posedge Clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.ResetAll = 1'b0; bus.level = 2'd1; bus.Starting_screen = 1'b0;
        bus.dot_eaten = 1'b0; bus.power_eaten = 1'b0; bus.ghost_hit = 1'b0; bus.frame_tick = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        compare_model();
    endtask

    typedef struct {
        bit       ra;
        bit [1:0] lvl;
        bit       ss, dot, pwr, gh, tick;
        int       e_state, e_dots, e_score, e_lives, e_fr, e_dying;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 240,   0, 3, 0, 0};
        vecs[1]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 239,  10, 3, 0, 0};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 238,  60, 3, 1, 0};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 238,  60, 3, 1, 0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 238, 260, 3, 1, 0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 237, 510, 3, 1, 0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 237, 510, 3, 1, 0};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 244, 510, 3, 0, 0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 244, 510, 3, 0, 0};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 243, 520, 3, 0, 0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 243, 520, 3, 0, 1};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 240, 520, 3, 0, 0};

        // Reset state against constants.
        do_reset();
        check("rst_state",       32'(bus.dbg_state),   0);
        check("rst_dots_left",   32'(bus.dots_left),   240);
        check("rst_dots_status", 32'(bus.dots_status), 1);
        check("rst_lives",       32'(bus.lives),       3);
        check("rst_score",       32'(bus.score),       0);
        check("rst_PAC_status",  32'(bus.PAC_status),  0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ra, vecs[i].lvl, vecs[i].ss, vecs[i].dot, vecs[i].pwr, vecs[i].gh, vecs[i].tick);
            check($sformatf("vec%0d_state", i), 32'(bus.dbg_state),  vecs[i].e_state);
            check($sformatf("vec%0d_dots", i),  32'(bus.dots_left),  vecs[i].e_dots);
            check($sformatf("vec%0d_score", i), 32'(bus.score),      vecs[i].e_score);
            check($sformatf("vec%0d_lives", i), 32'(bus.lives),      vecs[i].e_lives);
            check($sformatf("vec%0d_fr", i),    32'(bus.frightened), vecs[i].e_fr);
            check($sformatf("vec%0d_dying", i), 32'(bus.dying),      vecs[i].e_dying);
        end

        // Clear level 1 dot by dot, then one extra dot.
        do_reset();
        idle();
        for (int i = 0; i < 240; i++) begin
            step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 238) begin
                check("clear_dots_at_1",   32'(bus.dots_left),   1);
                check("clear_status_at_1", 32'(bus.dots_status), 1);
            end
        end
        check("clear_dots_0",   32'(bus.dots_left),   0);
        check("clear_status_0", 32'(bus.dots_status), 0);
        check("clear_score",    32'(bus.score),       2400);
        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("floor_dots",  32'(bus.dots_left), 0);
        check("floor_score", 32'(bus.score),     2400);

        // Level 2 reload keeps score and lives.
        step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("l2_dots",   32'(bus.dots_left),   244);
        check("l2_status", 32'(bus.dots_status), 1);
        check("l2_score",  32'(bus.score),       2400);
        check("l2_lives",  32'(bus.lives),       3);
        check("l2_state",  32'(bus.dbg_state),   0);
        idle();
        check("l2_play", 32'(bus.dbg_state), 1);

        // Frightened window: 119 ticks still frightened, bonus hit, expiry, then fatal hit.
        step(1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(119);
        check("fr_after_119", 32'(bus.frightened), 1);
        step(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fr_bonus_score", 32'(bus.score),     2650);
        check("fr_bonus_state", 32'(bus.dbg_state), 1);
        tick_n(1);
        idle();
        check("fr_expired", 32'(bus.frightened), 0);
        step(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hit_dying", 32'(bus.dying),     1);
        check("hit_state", 32'(bus.dbg_state), 2);

        // First death: 60 ticks then respawn.
        tick_n(59);
        check("dying_59", 32'(bus.dying), 1);
        tick_n(1);
        check("d1_lives",   32'(bus.lives),     2);
        check("d1_respawn", 32'(bus.respawn),   1);
        check("d1_state",   32'(bus.dbg_state), 1);
        check("d1_dots",    32'(bus.dots_left), 243);
        idle();
        check("d1_respawn_off", 32'(bus.respawn), 0);

        // Second and third deaths, game over, reload.
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(60);
        check("d2_lives", 32'(bus.lives), 1);
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick_n(60);
        check("d3_pac",   32'(bus.PAC_status), 1);
        check("d3_lives", 32'(bus.lives),      0);
        check("d3_state", 32'(bus.dbg_state),  3);
        idle();
        check("d3_pac_held", 32'(bus.PAC_status), 1);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("go_pac",   32'(bus.PAC_status), 0);
        check("go_lives", 32'(bus.lives),      3);
        check("go_score", 32'(bus.score),      0);
        check("go_dots",  32'(bus.dots_left),  240);

        // Last dot coincident with a fatal hit, then Starting_screen masking.
        idle();
        for (int i = 0; i < 239; i++) step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("last_dot_dots",   32'(bus.dots_left),   1);
        check("last_dot_status", 32'(bus.dots_status), 1);
        check("last_dot_state",  32'(bus.dbg_state),   2);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        step(1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ss_dots", 32'(bus.dots_left), 240);

        // Score saturation through repeated frightened ghost hits.
        step(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 340; i++) step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("score_sat", 32'(bus.score), 65535);

        // Randomized play, with PAC_status answered by ResetAll like pac_control does.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(bus.PAC_status ? 1'b1 : ($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
